// File: rtl/addr_bus_arbiter.sv
// addr_bus_arbiter: round-robin arbiter granting a shared address bus to one of NUM_REQ
// address registers. Optional ACCESS timeout is compiled in when ADDR_ARB_TIMEOUT_EN is defined.
module addr_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ-1:0]         post_inc,
  input  logic                       mem_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         inc,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    if (v == GW'(NUM_REQ-1)) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = v + GW'(1);
    end
  endfunction

  logic [0:0]         r_state = ST_IDLE;
  logic [GW-1:0]      r_rp    = '0;
  logic [GW-1:0]      r_gid   = '0;
  logic [NUM_REQ-1:0] r_grant = '0;

  logic [0:0]         w_state_nxt;
  logic [GW-1:0]      w_rp_nxt;
  logic [GW-1:0]      w_gid_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               w_pick_found;
  logic [GW-1:0]      w_pick_id;
  logic [GW-1:0]      w_cand;
  logic               w_access;
  logic               w_req_g;
  logic               w_done;
  logic               w_abort;
  logic               w_timeout;

  assign w_access = (r_state == ST_ACCESS);
  assign w_req_g  = req[r_gid];
  assign w_done   = w_access & w_req_g & mem_ready;
  assign w_abort  = w_access & (~w_req_g | w_timeout);

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    w_cand       = r_rp;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_pick_found && req[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_id    = w_cand;
      end else begin
        w_pick_found = w_pick_found;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  // Increment strobe completes on the same edge as the access; suppressed under reset.
  always_comb begin
    inc = '0;
    if (w_done && !reset && post_inc[r_gid]) begin
      inc = ONE_HOT0 << r_gid;
    end else begin
      inc = '0;
    end
  end

  // Next-state logic for the IDLE/ACCESS machine.
  always_comb begin
    w_state_nxt = r_state;
    w_rp_nxt    = r_rp;
    w_gid_nxt   = r_gid;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ST_ACCESS;
          w_gid_nxt   = w_pick_id;
          w_grant_nxt = ONE_HOT0 << w_pick_id;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (w_abort || (w_done && !lock[r_gid])) begin
          w_state_nxt = ST_IDLE;
          w_rp_nxt    = wrap_inc(r_gid);
          w_gid_nxt   = '0;
          w_grant_nxt = '0;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rp_nxt    = '0;
        w_gid_nxt   = '0;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rp    <= '0;
      r_gid   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rp    <= w_rp_nxt;
      r_gid   <= w_gid_nxt;
      r_grant <= w_grant_nxt;
    end
  end

`ifdef ADDR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt         = '0;
  logic          r_timeout_err = 1'b0;

  // Abort on the edge where the stalled-cycle count would reach TIMEOUT.
  assign w_timeout = w_access & ~mem_ready & (r_cnt == CW'(TIMEOUT - 1));

  // Stall counter and one-cycle abort flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (!w_access || w_done || w_abort) begin
        r_cnt <= '0;
      end else if (!mem_ready) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // Without the timeout feature TIMEOUT has no effect; the term below is always 0.
  assign w_timeout   = 1'b0 & (TIMEOUT > 0);
  assign timeout_err = 1'b0;
`endif

  assign grant    = r_grant;
  assign grant_id = r_gid;
  assign busy     = w_access;

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Scoreboard bench for addr_bus_arbiter: each scenario pushes per-cycle expectations
// and pops/compares them against the sampled outputs one cycle at a time.
module tb_addr_bus_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0] post_inc = '0;
  logic         mem_ready = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic [N-1:0] inc;
  logic         busy;
  logic         timeout_err;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [1:0]   gid;
    logic [N-1:0] inc;
    logic         busy;
    logic         terr;
  } obs_t;

  typedef struct packed {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] pinc;
    logic         mr;
    obs_t         exp;
  } row_t;

  obs_t sb_q[$];
  obs_t obs;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  addr_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .post_inc(post_inc),
    .mem_ready(mem_ready), .grant(grant), .grant_id(grant_id), .inc(inc),
    .busy(busy), .timeout_err(timeout_err)
  );

  assign obs = {grant, grant_id, inc, busy, timeout_err};

  function automatic row_t row(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                               input logic [N-1:0] pi, input logic mr, input logic [N-1:0] g,
                               input logic [1:0] id, input logic [N-1:0] i, input logic b,
                               input logic t);
    row_t x;
    x.rst = r; x.req = rq; x.lock = lk; x.pinc = pi; x.mr = mr;
    x.exp = {g, id, i, b, t};
    return x;
  endfunction

  task automatic apply(input row_t x);
    reset = x.rst; req = x.req; lock = x.lock; post_inc = x.pinc; mem_ready = x.mr;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lock = '0; post_inc = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t e, g;
    #1;
    checks++;
    if (obs !== obs_t'(0)) begin
      failures++;
      $display("FAIL powerup: got %b want %b", obs, obs_t'(0));
    end
    do_reset();
    rows.push_back(row(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    row_t rows[$];
    obs_t e, g;
    do_reset();
    rows.push_back(row(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL single[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    obs_t e, g;
    logic [N-1:0] oh;
    logic [1:0] id;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        rows.push_back(row(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
      end else begin
        id = 2'(((i - 1) / 2) % 4);
        oh = 4'b0001 << id;
        rows.push_back(row(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, oh, id, oh, 1'b1, 1'b0));
      end
    end
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL round_robin[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    row_t rows[$];
    obs_t e, g;
    do_reset();
    rows.push_back(row(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0101, 4'b1111, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      rows.push_back(row(1'b0, 4'b0101, 4'b0101, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0101, 4'b1111, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0001, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL lock[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    row_t rows[$];
    obs_t e, g;
    do_reset();
    rows.push_back(row(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0000, 4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL abort[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    obs_t e, g;
    do_reset();
    rows.push_back(row(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    rows.push_back(row(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset_mid[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    obs_t e, g;
    do_reset();
    rows.push_back(row(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
`ifdef ADDR_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++)
      rows.push_back(row(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
`else
    for (int i = 0; i < 100; i++)
      rows.push_back(row(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0));
`endif
    rows.push_back(row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < rows.size(); k++) begin
      apply(rows[k]); sb_q.push_back(rows[k].exp); #1;
      g = obs; e = sb_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL timeout[%0d]: got %b want %b", k, g, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_bus_arbiter.md
ADDR_BUS_ARBITER -- requirements
Module: addr_bus_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, the number of address-register requesters (2..8).
REQ-002 The module SHALL have parameter TIMEOUT, default 15, the maximum ACCESS cycles before abort; used only with the Configuration macro.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port req  input  NUM_REQ  per-requester request for the address bus.
REQ-006 The module SHALL have port lock  input  NUM_REQ  per-requester request to keep the grant after completion, for multi-byte access.
REQ-007 The module SHALL have port post_inc  input  NUM_REQ  per-requester request to increment its address register on completion.
REQ-008 The module SHALL have port mem_ready  input  1  memory accepts the current access this cycle.
REQ-009 The module SHALL have port grant  output  NUM_REQ  one-hot; drives the granted register's assert_addr.
REQ-010 The module SHALL have port grant_id  output  clog2(NUM_REQ)  index of the granted requester; 0 when idle.
REQ-011 The module SHALL have port inc  output  NUM_REQ  one-hot increment strobe to the granted register's inc.
REQ-012 The module SHALL have port busy  output  1  high while in ACCESS.
REQ-013 The module SHALL have port timeout_err  output  1  one-cycle abort pulse; constant 0 without the Configuration macro.

Function
REQ-014 The state machine SHALL have exactly two states, IDLE and ACCESS.
REQ-015 In IDLE with any req bit set, the arbiter SHALL pick the first set bit at or after the round-robin pointer rp (wrapping at NUM_REQ-1 to 0), register it as gid, and enter ACCESS at the next edge.
REQ-016 grant SHALL be registered: grant[gid]=1 from the first cycle after the request is sampled, and grant SHALL be all-zero in IDLE.
REQ-017 In IDLE with req all-zero, the arbiter SHALL stay in IDLE with rp unchanged.
REQ-018 In ACCESS, a cycle with mem_ready=1 and req[gid]=1 SHALL complete the access.
REQ-019 inc SHALL be combinational: inc[gid] = ACCESS & mem_ready & req[gid] & post_inc[gid], so the register updates on the completing edge; all other inc bits SHALL be 0.
REQ-020 On completion with lock[gid]=1, the arbiter SHALL stay in ACCESS with the same gid, with no dead cycle and no re-arbitration.
REQ-021 On completion with lock[gid]=0, the arbiter SHALL return to IDLE and set rp=(gid+1) mod NUM_REQ.
REQ-022 Every return from ACCESS to IDLE SHALL spend one IDLE cycle, so back-to-back accesses by different requesters have a one-cycle gap with grant all-zero.
REQ-023 If req[gid] drops in ACCESS, the access SHALL abort: return to IDLE, no inc pulse, rp=(gid+1) mod NUM_REQ, and mem_ready in that cycle ignored.
REQ-024 Changes to req, lock or post_inc of non-granted requesters during ACCESS SHALL have no effect.
REQ-025 At most one grant bit and at most one inc bit SHALL be high in any cycle.

Reset
REQ-026 With reset=1 at a rising edge, the next state SHALL be IDLE with rp=0, gid=0, the timeout counter cleared, and grant, inc, busy and timeout_err all 0.
REQ-027 Reset SHALL take priority over all inputs, including mid-ACCESS and a coincident mem_ready; no inc pulse SHALL occur in any cycle where reset=1.
REQ-028 Power-up register values SHALL equal the reset values.

Configuration
REQ-029 When ADDR_ARB_TIMEOUT_EN is defined, a counter SHALL clear on entry to ACCESS and on each completion, and SHALL increment on each ACCESS cycle without mem_ready.
REQ-030 When ADDR_ARB_TIMEOUT_EN is defined and the counter reaches TIMEOUT, the access SHALL abort as in REQ-023 and timeout_err SHALL pulse high for exactly the cycle after the abort.
REQ-031 When ADDR_ARB_TIMEOUT_EN is not defined, no counter logic SHALL exist, ACCESS SHALL wait indefinitely for mem_ready, and timeout_err SHALL be tied to 0.

Verification
REQ-032 Reset, then req=0001, mem_ready=1, post_inc=0001 -> grant=0001 one cycle later, inc=0001 for one cycle, then IDLE with rp=1.
REQ-033 Hold req=1111 with lock=0 and mem_ready=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
REQ-034 Grant 2 with lock=0100, post_inc=0100, and mem_ready high for 3 cycles -> grant=0100 held, inc=0100 on 3 consecutive cycles, grant_id=2 throughout.
REQ-035 Grant 1, then drop req[1] with mem_ready=1 in the same cycle -> no inc, IDLE next cycle, next grant goes to 2 if requested.
REQ-036 Assert reset while in ACCESS with mem_ready=1 and post_inc set -> no inc pulse; next cycle IDLE, grant=0, rp=0.
REQ-037 With ADDR_ARB_TIMEOUT_EN, TIMEOUT=15, and mem_ready held 0 -> abort after 15 ACCESS cycles and timeout_err=1 for one cycle; without the macro, grant is still held at cycle 100.
